rv_mc_controller: RTL



---
 rtl/rv_ctrl_pkg.sv | 77 +++++++
 rtl/rv_alu_decoder.sv | 31 +++
 rtl/rv_mc_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, mux selects,
// ALU operations and the main FSM state encoding.
package rv_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU decoder modes: plain add, branch compare, full funct decode
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    // beq/bne use zero, blt/bge use the signed less-than flag
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lt);
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU operation decode from aluop mode and funct fields; purely combinational.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_aluop)
            ALUOP_BRANCH: o_alu_control = i_funct3[2] ? ALU_SLT : ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // sub only for R-type; I-type has no subi so bit 30 is immediate
                    3'b000:  o_alu_control = (i_funct7_5 && i_op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_controller.sv
// Main control FSM of the multi-cycle RV32I core (Moore outputs, branch PCWrite Mealy).
// Optional RV_MC_MEM_STALL_EN adds mem_ready to stall FETCH/MEMREAD/MEMWRITE.
module rv_mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
`ifdef RV_MC_MEM_STALL_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_aluop;
    logic       w_mem_ready;

`ifdef RV_MC_MEM_STALL_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= state_t'(RESET_STATE);
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        ImmSrc       = IMM_I;
        w_aluop      = ALUOP_ADD;
        RegWrite     = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite      = w_mem_ready;
                PCWrite      = w_mem_ready;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (op == OP_BRANCH)   ImmSrc = IMM_B;
                else if (op == OP_JAL) ImmSrc = IMM_J;
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_LUI:            w_next_state = S_LUI;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                ImmSrc       = op[5] ? IMM_S : IMM_I;
                w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_next_state = w_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                MemWrite     = w_mem_ready;
                w_next_state = w_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA      = SRCA_RD1;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                w_aluop = ALUOP_BRANCH;
                PCWrite = branch_taken(funct3, zero, lt);
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                PCWrite      = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_JALR2;
            end
            // ALUOut holds rs1+imm from JALR; ALU meanwhile forms OldPC+4 for the link
            S_JALR2: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                PCWrite      = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    rv_alu_decoder u_alu_decoder (
        .i_aluop       (w_aluop),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7_5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

    assign state_o = r_state;

endmodule
